// File: rtl/dmem_port_arbiter.sv
// Shares a single-port data memory between the CPU and debug ports with round-robin
// arbitration, registered read return and a word-by-word clear sequencer.
module dmem_port_arbiter #(
  parameter int DEPTH  = 100,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_mem,
  input  logic              reset_mem,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              addr_err,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  input  logic [DATA_W-1:0] mem_RD
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic                last_dbg_q;
  logic [DATA_W-1:0]   cpu_rdata_q, dbg_rdata_q;
  logic                cpu_rvalid_q, dbg_rvalid_q;
  logic                addr_err_q, clr_done_q;

  logic                idle_s, cpu_gnt_s, dbg_gnt_s, cpu_ok_s, dbg_ok_s;

  // last_dbg_q set means debug was granted last, so the CPU wins the next tie
  assign idle_s    = (state_q == ST_IDLE);
  assign cpu_gnt_s = idle_s & cpu_req & (~dbg_req | last_dbg_q);
  assign dbg_gnt_s = idle_s & dbg_req & (~cpu_req | ~last_dbg_q);
  assign cpu_ok_s  = (cpu_addr < DEPTH_A);
  assign dbg_ok_s  = (dbg_addr < DEPTH_A);

  always_comb begin
    mem_wr = 1'b0;
    mem_A  = '0;
    mem_WD = '0;
    if (state_q == ST_CLEAR) begin
      mem_wr = 1'b1;
      mem_A  = clr_ptr_q;
    end else if (cpu_gnt_s) begin
      mem_wr = cpu_we & cpu_ok_s;
      mem_A  = cpu_addr;
      mem_WD = cpu_wdata;
    end else if (dbg_gnt_s) begin
      mem_wr = dbg_we & dbg_ok_s;
      mem_A  = dbg_addr;
      mem_WD = dbg_wdata;
    end else begin
      mem_wr = 1'b0;
    end
  end

  always_ff @(posedge clk_mem or posedge reset_mem) begin
    if (reset_mem) begin
      state_q      <= ST_IDLE;
      clr_ptr_q    <= '0;
      last_dbg_q   <= 1'b1;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      clr_done_q   <= 1'b0;
    end else begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      clr_done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_gnt_s) begin
            last_dbg_q <= 1'b0;
            addr_err_q <= ~cpu_ok_s;
            if (!cpu_we) begin
              cpu_rdata_q  <= cpu_ok_s ? mem_RD : '0;
              cpu_rvalid_q <= 1'b1;
            end
          end else if (dbg_gnt_s) begin
            last_dbg_q <= 1'b1;
            addr_err_q <= ~dbg_ok_s;
            if (!dbg_we) begin
              dbg_rdata_q  <= dbg_ok_s ? mem_RD : '0;
              dbg_rvalid_q <= 1'b1;
            end
          end
          if (clr_start) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_ptr_q == LAST_A) begin
            state_q    <= ST_IDLE;
            clr_ptr_q  <= '0;
            clr_done_q <= 1'b1;
          end else begin
            clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          clr_ptr_q <= '0;
        end
      endcase
    end
  end

  assign cpu_gnt    = cpu_gnt_s;
  assign dbg_gnt    = dbg_gnt_s;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign addr_err   = addr_err_q;
  assign clr_done   = clr_done_q;
  assign clr_busy   = (state_q == ST_CLEAR);

endmodule
